can_clic_seq: RTL and testbench

CAN_CLIC_SEQ -- requirements
Module: can_clic_seq

---
 rtl/can_clic_seq.sv | 154 +++++++++++++++
 tb/tb_can_clic_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_clic_seq.sv
// rtl/can_clic_seq.sv - bit-serial CLIC-style interrupt arbiter with pending bits and claim handshake
// Optional strict threshold check enabled by macro CAN_CLIC_THRESHOLD_EN.
module can_clic_seq #(
    parameter int NR_INDEX_BITS = 3,
    parameter int NR_PRIO_BITS  = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [2**NR_INDEX_BITS-1:0]                   pend_set,
    input  logic [2**NR_INDEX_BITS-1:0]                   enable,
    input  logic [(2**NR_INDEX_BITS)*NR_PRIO_BITS-1:0]    prio,
    input  logic [NR_PRIO_BITS-1:0]                       threshold,
    input  logic                                          start,
    input  logic                                          ack,
    output logic                                          busy,
    output logic                                          is_interrupt,
    output logic [NR_INDEX_BITS-1:0]                      index,
    output logic [NR_PRIO_BITS-1:0]                       win_prio,
    output logic                                          none
);

    localparam int N   = 2**NR_INDEX_BITS;
    localparam int P   = NR_PRIO_BITS;
    localparam int PBW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {IDLE, ARB, RESOLVE, PRESENT} state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             pend_q, pend_d;
    logic [N-1:0]             cont_q, cont_d;
    logic [N*P-1:0]           prio_q, prio_d;
    logic [PBW-1:0]           pb_q, pb_d;
    logic [NR_INDEX_BITS-1:0] idx_q, idx_d;
    logic [P-1:0]             wprio_q, wprio_d;
    logic                     none_q, none_d;
    logic [P-1:0]             thr_q, thr_d;

    logic [N-1:0]             bit_col;
    logic                     or_value;
    logic                     found;
    logic [NR_INDEX_BITS-1:0] win_idx;
    logic [P-1:0]             win_pr;
    logic                     accept;

    always_comb begin : datapath
        bit_col = '0;
        for (int i = 0; i < N; i++) begin
            bit_col[i] = prio_q[i*P + int'(pb_q)];
        end
        or_value = |(cont_q & bit_col);
        found    = |cont_q;
        // Descending scan so the lowest remaining index wins ties
        win_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (cont_q[i]) begin
                win_idx = NR_INDEX_BITS'(i);
            end
        end
        win_pr = prio_q[int'(win_idx)*P +: P];
`ifdef CAN_CLIC_THRESHOLD_EN
        accept = found && (win_pr > thr_q);
`else
        accept = found;
`endif
    end

`ifndef CAN_CLIC_THRESHOLD_EN
    logic unused_threshold;
    assign unused_threshold = ^thr_q;
`endif

    always_comb begin : fsm
        state_d = state_q;
        pend_d  = pend_q;
        cont_d  = cont_q;
        prio_d  = prio_q;
        pb_d    = pb_q;
        idx_d   = idx_q;
        wprio_d = wprio_q;
        none_d  = 1'b0;
        thr_d   = thr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cont_d  = enable & pend_q;
                    prio_d  = prio;
                    thr_d   = threshold;
                    pb_d    = PBW'(P-1);
                    state_d = ARB;
                end
            end
            ARB: begin
                if (or_value) begin
                    cont_d = cont_q & bit_col;
                end
                if (pb_q == '0) begin
                    state_d = RESOLVE;
                end else begin
                    pb_d = pb_q - PBW'(1);
                end
            end
            RESOLVE: begin
                if (accept) begin
                    idx_d   = win_idx;
                    wprio_d = win_pr;
                    state_d = PRESENT;
                end else begin
                    none_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (ack) begin
                    pend_d[idx_q] = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh set in the claim cycle must survive the ack clear
        pend_d = pend_d | pend_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cont_q  <= '0;
            prio_q  <= '0;
            pb_q    <= '0;
            idx_q   <= '0;
            wprio_q <= '0;
            none_q  <= 1'b0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cont_q  <= cont_d;
            prio_q  <= prio_d;
            pb_q    <= pb_d;
            idx_q   <= idx_d;
            wprio_q <= wprio_d;
            none_q  <= none_d;
            thr_q   <= thr_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign is_interrupt = (state_q == PRESENT);
    assign index        = idx_q;
    assign win_prio     = wprio_q;
    assign none         = none_q;

endmodule

// File: tb/tb_can_clic_seq.sv
// tb/tb_can_clic_seq.sv - directed scoreboard bench for can_clic_seq (N=8, P=3)
module tb_can_clic_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pend_set;
    logic [7:0]  enable;
    logic [23:0] prio;
    logic [2:0]  threshold;
    logic        start;
    logic        ack;
    logic        busy;
    logic        is_interrupt;
    logic [2:0]  index;
    logic [2:0]  win_prio;
    logic        none;

    can_clic_seq #(.NR_INDEX_BITS(3), .NR_PRIO_BITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .pend_set     (pend_set),
        .enable       (enable),
        .prio         (prio),
        .threshold    (threshold),
        .start        (start),
        .ack          (ack),
        .busy         (busy),
        .is_interrupt (is_interrupt),
        .index        (index),
        .win_prio     (win_prio),
        .none         (none)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_int;
        logic [2:0] idx;
        logic [2:0] pr;
    } exp_t;

    exp_t sb[$];
    int   n_eval = 0;
    int   n_fail = 0;
    int   lat    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_prio(input int i, input logic [2:0] v);
        prio[i*3 +: 3] = v;
    endtask

    task automatic pend(input logic [7:0] mask);
        pend_set = mask;
        tick();
        pend_set = '0;
    endtask

    task automatic begin_round(input logic ei, input logic [2:0] eidx, input logic [2:0] epr);
        exp_t e;
        e.is_int = ei;
        e.idx    = eidx;
        e.pr     = epr;
        sb.push_back(e);
        start = 1'b1;
        lat   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_round(input string tag);
        exp_t e;
        while (!(is_interrupt || none) && lat < 20) tick();
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!(is_interrupt || none)) begin
                check({tag, "_timeout"}, 32'(is_interrupt | none), 32'd1);
            end else begin
                check({tag, "_latency"}, 32'(lat), 32'd5);
                check({tag, "_is_int"}, 32'(is_interrupt), 32'(e.is_int));
                check({tag, "_none"}, 32'(none), 32'(!e.is_int));
                if (e.is_int) begin
                    check({tag, "_index"}, 32'(index), 32'(e.idx));
                    check({tag, "_prio"}, 32'(win_prio), 32'(e.pr));
                end else begin
                    tick();
                    check({tag, "_none_pulse"}, 32'(none), 32'd0);
                end
            end
        end
    endtask

    task automatic ack_win(input string tag, input logic [2:0] eidx);
        tick();
        check({tag, "_held"}, 32'(is_interrupt), 32'd1);
        check({tag, "_held_idx"}, 32'(index), 32'(eidx));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_drop"}, 32'(is_interrupt), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        pend_set  = '0;
        enable    = 8'hFF;
        prio      = '0;
        threshold = '0;
        start     = 1'b0;
        ack       = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_int", 32'(is_interrupt), 32'd0);
        check("rst_none", 32'(none), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_prio", 32'(win_prio), 32'd0);
        reset = 1'b0;
        tick();

        // Two priorities, then the loser after the winner is claimed
        set_prio(2, 3'd5);
        set_prio(6, 3'd3);
        pend(8'b0100_0100);
        begin_round(1'b1, 3'd2, 3'd5);
        check("arb_busy", 32'(busy), 32'd1);
        finish_round("r2");
        ack_win("r2", 3'd2);
        begin_round(1'b1, 3'd6, 3'd3);
        finish_round("r6");
        ack_win("r6", 3'd6);

        // Equal priorities: lowest index first
        set_prio(1, 3'd7);
        set_prio(4, 3'd7);
        pend(8'b0001_0010);
        begin_round(1'b1, 3'd1, 3'd7);
        finish_round("tie1");
        ack_win("tie1", 3'd1);
        begin_round(1'b1, 3'd4, 3'd7);
        finish_round("tie4");
        ack_win("tie4", 3'd4);

        // Disabled pending entry gives none and stays pending
        set_prio(3, 3'd2);
        enable = 8'hF7;
        pend(8'b0000_1000);
        begin_round(1'b0, 3'd0, 3'd0);
        finish_round("dis3");
        enable = 8'hFF;
        begin_round(1'b1, 3'd3, 3'd2);
        finish_round("en3");
        ack_win("en3", 3'd3);

        // Threshold handling
        set_prio(0, 3'd4);
        threshold = 3'd4;
        pend(8'b0000_0001);
`ifdef CAN_CLIC_THRESHOLD_EN
        begin_round(1'b0, 3'd0, 3'd0);
        finish_round("thr4");
        threshold = 3'd3;
        begin_round(1'b1, 3'd0, 3'd4);
        finish_round("thr3");
        ack_win("thr3", 3'd0);
`else
        begin_round(1'b1, 3'd0, 3'd4);
        finish_round("thr4");
        ack_win("thr4", 3'd0);
        threshold = 3'd7;
        pend(8'b0000_0001);
        begin_round(1'b1, 3'd0, 3'd4);
        finish_round("thr7");
        ack_win("thr7", 3'd0);
`endif
        threshold = 3'd0;

        // Inputs changed after capture, start re-asserted, late pend_set
        set_prio(5, 3'd2);
        pend(8'b0010_0000);
        begin_round(1'b1, 3'd5, 3'd2);
        set_prio(5, 3'd7);
        enable = 8'h00;
        start  = 1'b1;
        pend(8'b0000_0010);
        start  = 1'b0;
        finish_round("snap5");
        ack_win("snap5", 3'd5);
        enable = 8'hFF;
        begin_round(1'b1, 3'd1, 3'd7);
        finish_round("late1");
        ack_win("late1", 3'd1);

        // Priority-0 winner at threshold 0
        set_prio(7, 3'd0);
        pend(8'b1000_0000);
`ifdef CAN_CLIC_THRESHOLD_EN
        begin_round(1'b0, 3'd0, 3'd0);
        finish_round("p0");
`else
        begin_round(1'b1, 3'd7, 3'd0);
        finish_round("p0");
        ack_win("p0", 3'd7);
`endif

        // Reset in the second ARB cycle
        pend(8'b0000_1001);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_int", 32'(is_interrupt), 32'd0);
        check("mid_none", 32'(none), 32'd0);
        check("mid_index", 32'(index), 32'd0);
        check("mid_prio", 32'(win_prio), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        begin_round(1'b0, 3'd0, 3'd0);
        finish_round("post_rst");

        // Ack and pend_set on the same index in the claim cycle
        pend(8'b0010_0000);
        begin_round(1'b1, 3'd5, 3'd7);
        finish_round("same5");
        tick();
        ack      = 1'b1;
        pend_set = 8'b0010_0000;
        tick();
        ack      = 1'b0;
        pend_set = '0;
        check("same5_drop", 32'(is_interrupt), 32'd0);
        begin_round(1'b1, 3'd5, 3'd7);
        finish_round("keep5");
        ack_win("keep5", 3'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
